sram_1rw1r_masked_clr: RTL and testbench

//  Parametrised behavioural SRAM macro model for cache tag/data/valid arrays.

---
 rtl/sram_1rw1r_masked_clr.sv | 195 +++++++++++++++++++
 tb/tb_sram_1rw1r_masked_clr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw1r_masked_clr.sv
// sram_1rw1r_masked_clr
//   Behavioural 1RW + 1R SRAM model for cache tag/data/valid arrays.
//   Port 0 reads or writes with per-lane write masking. Port 1 is read-only.
//   A clear sequencer writes INIT_VALUE to every entry after reset or on a
//   clr request. While the sweep runs (busy=1), all user accesses are ignored.
//   Both ports have a read latency of one cycle, and every output is registered.
//   A port 1 read that hits the address port 0 writes at the same edge returns
//   the merged (write-through) word.

module sram_1rw1r_masked_clr #(
    parameter int                    DATA_WIDTH  = 23,
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    WMASK_WIDTH = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    output logic                   busy,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   rvalid0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   rvalid1
);

    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Lane-wise merge: a lane comes from new_word where its mask bit is set.
    // Otherwise the lane comes from old_word.
    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0]  old_word,
        input logic [DATA_WIDTH-1:0]  new_word,
        input logic [WMASK_WIDTH-1:0] mask
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (mask[i]) begin
                merged[i*LANE_WIDTH +: LANE_WIDTH] = new_word[i*LANE_WIDTH +: LANE_WIDTH];
            end else begin
                merged[i*LANE_WIDTH +: LANE_WIDTH] = old_word[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        return merged;
    endfunction

    // Storage array. It has no reset; the clear sweep initialises it.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic                  busy_q,    busy_d;
    logic [DATA_WIDTH-1:0] dout0_q,   dout0_d;
    logic [DATA_WIDTH-1:0] dout1_q,   dout1_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;

    // Write port of the array for this edge (either the sweep or user port 0).
    logic                  mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_waddr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;

    // Decoded port 0 access, plus the word that a port 0 write would store.
    logic                  p0_wr_s;
    logic                  p0_rd_s;
    logic                  p1_rd_s;
    logic [DATA_WIDTH-1:0] p0_old_s;
    logic [DATA_WIDTH-1:0] p0_merged_s;

    assign p0_wr_s     = ~csb0 & ~web0;
    assign p0_rd_s     = ~csb0 &  web0;
    assign p1_rd_s     = ~csb1;
    assign p0_old_s    = mem_q[addr0];
    assign p0_merged_s = lane_merge(p0_old_s, din0, wmask0);

    // Next-state logic: clear sweep sequencing, user accesses, and output data.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        busy_d      = busy_q;
        dout0_d     = dout0_q;
        dout1_d     = dout1_q;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_waddr_d = clr_idx_q;
        mem_wdata_d = INIT_VALUE;

        case (state_q)
            ST_CLEAR: begin
                // Sweep one entry per edge. User ports and clr are ignored.
                mem_we_d    = 1'b1;
                mem_waddr_d = clr_idx_q;
                mem_wdata_d = INIT_VALUE;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    clr_idx_d = {ADDR_WIDTH{1'b0}};
                end else begin
                    clr_idx_d = clr_idx_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end

            ST_IDLE: begin
                // Port 0: masked write, or a read of the contents before the edge.
                if (p0_wr_s) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = addr0;
                    mem_wdata_d = p0_merged_s;
                end else if (p0_rd_s) begin
                    dout0_d   = p0_old_s;
                    rvalid0_d = 1'b1;
                end else begin
                    dout0_d   = dout0_q;
                end

                // Port 1: a read that collides with a port 0 write sees the merged word.
                if (p1_rd_s) begin
                    if (p0_wr_s && (addr1 == addr0)) begin
                        dout1_d = p0_merged_s;
                    end else begin
                        dout1_d = mem_q[addr1];
                    end
                    rvalid1_d = 1'b1;
                end else begin
                    dout1_d = dout1_q;
                end

                // A clear request lets this edge's accesses finish; the sweep starts next edge.
                if (clr) begin
                    state_d   = ST_CLEAR;
                    busy_d    = 1'b1;
                    clr_idx_d = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_CLEAR;
                busy_d    = 1'b1;
                clr_idx_d = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Control and output registers, with synchronous reset into a fresh sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= {ADDR_WIDTH{1'b0}};
            busy_q    <= 1'b1;
            dout0_q   <= {DATA_WIDTH{1'b0}};
            dout1_q   <= {DATA_WIDTH{1'b0}};
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
            dout0_q   <= dout0_d;
            dout1_q   <= dout1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // Array write. Nothing is written on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    assign busy    = busy_q;
    assign dout0   = dout0_q;
    assign dout1   = dout1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_sram_1rw1r_masked_clr.sv
// Directed testbench for sram_1rw1r_masked_clr (32-bit words, 16 entries, 4 byte lanes).

module tb_sram_1rw1r_masked_clr;

    localparam int          DW   = 32;
    localparam int          AW   = 4;
    localparam int          MW   = 4;
    localparam logic [31:0] INIT = 32'hDEAD_0000;

    logic          clk = 1'b0;
    logic          rst, clr, busy;
    logic          csb0, web0, csb1;
    logic [MW-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, dout0, dout1;
    logic          rvalid0, rvalid1;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;
    logic [31:0] held0, held1, exp_word;

    sram_1rw1r_masked_clr #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .WMASK_WIDTH(MW),
        .INIT_VALUE (INIT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .busy   (busy),
        .csb0   (csb0),
        .web0   (web0),
        .wmask0 (wmask0),
        .addr0  (addr0),
        .din0   (din0),
        .dout0  (dout0),
        .rvalid0(rvalid0),
        .csb1   (csb1),
        .addr1  (addr1),
        .dout1  (dout1),
        .rvalid1(rvalid1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; idle(); wmask0 = 4'h0; addr0 = 4'd0; addr1 = 4'd0; din0 = 32'd0;
        tick(); tick();

        // 1. Reset state, then busy lasts exactly 16 cycles after rst is released.
        check("rst_busy",    32'(busy),    32'd1);
        check("rst_dout0",   dout0,        32'd0);
        check("rst_dout1",   dout1,        32'd0);
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rvalid1", 32'(rvalid1), 32'd0);
        rst = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin cnt++; tick(); end
        check("init_busy_len", 32'(cnt), 32'd16);
        for (int a = 0; a < 16; a++) begin
            csb1 = 1'b0; addr1 = 4'(a);
            tick();
            check("init_rd_dout1",   dout1,        INIT);
            check("init_rd_rvalid1", 32'(rvalid1), 32'd1);
        end
        idle(); tick();
        check("p1_idle_rvalid1", 32'(rvalid1), 32'd0);

        // 2. Full write, then a masked write, then a port 0 read.
        csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd3; din0 = 32'h1122_3344; wmask0 = 4'hF;
        tick();
        check("wr_rvalid0", 32'(rvalid0), 32'd0);
        din0 = 32'hAABB_CCDD; wmask0 = 4'b0101;
        tick();
        web0 = 1'b1;
        tick();
        check("mask_rd_dout0",   dout0,        32'h11BB_33DD);
        check("mask_rd_rvalid0", 32'(rvalid0), 32'd1);
        idle(); tick();
        check("hold_dout0",    dout0,        32'h11BB_33DD);
        check("pulse_rvalid0", 32'(rvalid0), 32'd0);

        // 3. Write-through collision: first with a full mask, then with a partial mask.
        csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd5; din0 = 32'hCAFE_F00D; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 4'd5;
        tick();
        check("coll_dout1",   dout1,        32'hCAFE_F00D);
        check("coll_rvalid1", 32'(rvalid1), 32'd1);
        check("coll_rvalid0", 32'(rvalid0), 32'd0);
        din0 = 32'h1234_5678; wmask0 = 4'b0011;
        tick();
        check("coll_mask_dout1", dout1, 32'hCAFE_5678);
        csb1 = 1'b1; web0 = 1'b1;
        tick();
        check("coll_mask_dout0", dout0, 32'hCAFE_5678);

        // 4. Fill every entry, then clr. A read on the clr edge still completes.
        for (int a = 0; a < 16; a++) begin
            csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 4'(a);
            din0 = (32'h0101_0101 * 32'(a)) ^ 32'h5A5A_0000;
            tick();
        end
        idle();
        clr = 1'b1; csb1 = 1'b0; addr1 = 4'd3;
        tick();
        check("clr_edge_dout1",   dout1,        32'h5959_0303);
        check("clr_edge_rvalid1", 32'(rvalid1), 32'd1);
        check("clr_busy",         32'(busy),    32'd1);
        held0 = dout0; held1 = dout1;
        // Accesses during the sweep: port 0 writes entry 0, port 1 reads; clr is pulsed.
        clr = 1'b0; csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd0; din0 = 32'hFFFF_FFFF; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 4'd9;
        cnt = 0;
        do begin
            cnt++;
            clr = (cnt == 3);
            tick();
            if (busy) begin
                check("busy_rvalid0", 32'(rvalid0), 32'd0);
                check("busy_rvalid1", 32'(rvalid1), 32'd0);
                check("busy_dout0",   dout0,        held0);
                check("busy_dout1",   dout1,        held1);
            end else begin
                check("busy_end_idle", 32'(busy), 32'd0);
            end
        end while (busy && cnt < 40);
        check("clr_busy_len", 32'(cnt), 32'd16);
        idle(); tick();
        check("no_resweep_busy", 32'(busy), 32'd0);
        for (int a = 0; a < 16; a++) begin
            csb1 = 1'b0; addr1 = 4'(a);
            tick();
            check("clr_rd_dout1", dout1, INIT);
        end
        idle();

        // 5. rst in the middle of a sweep restarts the sweep.
        clr = 1'b1; tick(); clr = 1'b0;
        check("sweep2_busy", 32'(busy), 32'd1);
        repeat (6) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_busy",  32'(busy), 32'd1);
        check("midrst_dout0", dout0,     32'd0);
        check("midrst_dout1", dout1,     32'd0);
        cnt = 0;
        while (busy && cnt < 40) begin cnt++; tick(); end
        check("midrst_busy_len", 32'(cnt), 32'd16);

        // 6. Chip selects high with random traffic: no effect at all.
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 4'd4; din0 = 32'h4444_4444;
        tick();
        web0 = 1'b1; csb1 = 1'b0; addr1 = 4'd4;
        tick();
        check("pre_cs_dout0", dout0, 32'h4444_4444);
        check("pre_cs_dout1", dout1, 32'h4444_4444);
        idle();
        for (int i = 0; i < 10; i++) begin
            addr0 = 4'($urandom_range(15)); addr1 = 4'($urandom_range(15));
            din0 = $urandom; web0 = 1'($urandom_range(1)); wmask0 = 4'hF;
            tick();
            check("cs_rvalid0", 32'(rvalid0), 32'd0);
            check("cs_rvalid1", 32'(rvalid1), 32'd0);
            check("cs_dout0",   dout0,        32'h4444_4444);
            check("cs_dout1",   dout1,        32'h4444_4444);
        end
        idle(); web0 = 1'b1;
        for (int a = 0; a < 16; a++) begin
            csb1 = 1'b0; addr1 = 4'(a);
            exp_word = (a == 4) ? 32'h4444_4444 : INIT;
            tick();
            check("cs_mem_dout1", dout1, exp_word);
        end
        idle(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
